// File: rtl/spi_arb_pkg.sv
// Shared types and sizes for the SPI master arbiter.
package spi_arb_pkg;

  localparam int CMD_W   = 16;
  localparam int MAX_REQ = 8;
  localparam int ID_W    = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    BUSY,
    GAP
  } arb_state_t;

endpackage

// File: rtl/spi_arb_rr_arbiter.sv
// Round-robin pick among requesters: priority starts just above the last owner.
module rr_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  input  logic [ID_W-1:0]    upd_id,
  output logic               any_req,
  output logic [ID_W-1:0]    win_id
);

  logic [ID_W-1:0] r_last;
  int              w_dist;
  int              w_best;

  // Reset to the top index so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= ID_W'(NUM_REQ - 1);
    end else if (adv) begin
      r_last <= upd_id;
    end
  end

  // Distance 0 is the slot right after r_last; smallest distance among set bits wins.
  always_comb begin
    w_best = NUM_REQ;
    w_dist = 0;
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + 2 * NUM_REQ - 1 - int'(r_last)) % NUM_REQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        win_id = ID_W'(i);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/spi_arb.sv
// Shares one 16-bit SPI command/response master among NUM_REQ requesters with
// round-robin grants and an enforced idle gap after every transaction.
//
// state | meaning
// IDLE  | waiting for any request
// ISSUE | command latched, start strobe to master this cycle
// BUSY  | waiting for master completion
// GAP   | post-transaction idle; requests ignored until the counter hits 0
module spi_arb
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int GAP_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       req_done,
  output logic [CMD_W-1:0]         req_rd_data,
  output logic                     mst_wrt,
  output logic [CMD_W-1:0]         mst_cmd,
  input  logic                     mst_done,
  input  logic [CMD_W-1:0]         mst_rd_data,
  output logic                     busy,
  output logic [ID_W-1:0]          gnt_id
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  arb_state_t         r_state;
  arb_state_t         w_next;
  logic [GW-1:0]      r_gap_cnt;
  logic [NUM_REQ-1:0] r_req_done;
  logic [CMD_W-1:0]   r_rd_data;
  logic [CMD_W-1:0]   r_mst_cmd;
  logic               r_mst_wrt;
  logic               r_busy;
  logic [ID_W-1:0]    r_gnt_id;

  logic               w_any;
  logic [ID_W-1:0]    w_win;
  logic [CMD_W-1:0]   w_win_cmd;
  logic               w_grant;
  logic               w_done_evt;
  logic               w_gap_end;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .adv     (w_done_evt),
    .upd_id  (r_gnt_id),
    .any_req (w_any),
    .win_id  (w_win)
  );

  always_comb begin
    w_win_cmd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_win_cmd = req_cmd[i*CMD_W +: CMD_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_done_evt = 1'b0;
    w_gap_end  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          w_grant = 1'b1;
          w_next  = ISSUE;
        end
      end
      ISSUE: begin
        w_next = BUSY;
      end
      BUSY: begin
        if (mst_done) begin
          w_done_evt = 1'b1;
          w_next     = GAP;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) begin
          w_gap_end = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath; mst_wrt is registered from the grant so it is high exactly while in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mst_wrt  <= 1'b0;
      r_mst_cmd  <= '0;
      r_gnt_id   <= '0;
      r_busy     <= 1'b0;
      r_rd_data  <= '0;
      r_req_done <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_mst_wrt <= w_grant;
      if (w_grant) begin
        r_gnt_id  <= w_win;
        r_mst_cmd <= w_win_cmd;
      end
      if (w_grant) begin
        r_busy <= 1'b1;
      end else if (w_gap_end) begin
        r_busy <= 1'b0;
      end
      if (w_done_evt) begin
        r_rd_data <= mst_rd_data;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        r_req_done[i] <= w_done_evt && (r_gnt_id == ID_W'(i));
      end
      if (w_done_evt) begin
        r_gap_cnt <= GW'(GAP_CYC - 1);
      end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - GW'(1);
      end
    end
  end

  assign req_done    = r_req_done;
  assign req_rd_data = r_rd_data;
  assign mst_wrt     = r_mst_wrt;
  assign mst_cmd     = r_mst_cmd;
  assign busy        = r_busy;
  assign gnt_id      = r_gnt_id;

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb with two requesters and a four-cycle gap.
module tb_spi_arb;
  import spi_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [31:0] req_cmd = '0;
  logic [1:0]  req_done;
  logic [15:0] req_rd_data;
  logic        mst_wrt;
  logic [15:0] mst_cmd;
  logic        mst_done = 1'b0;
  logic [15:0] mst_rd_data = '0;
  logic        busy;
  logic [2:0]  gnt_id;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic seen_done1 = 1'b0;

  spi_arb #(.NUM_REQ(2), .GAP_CYC(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_cmd     (req_cmd),
    .req_done    (req_done),
    .req_rd_data (req_rd_data),
    .mst_wrt     (mst_wrt),
    .mst_cmd     (mst_cmd),
    .mst_done    (mst_done),
    .mst_rd_data (mst_rd_data),
    .busy        (busy),
    .gnt_id      (gnt_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (req_done[1] === 1'b1) seen_done1 = 1'b1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Negedges until mst_wrt is seen (bounded); caller compares the count.
  task automatic wait_wrt(output int n);
    n = 0;
    while (mst_wrt !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if ({mst_wrt, mst_cmd} !== 17'h0) begin n_bad++; $display("FAIL reset_mst: got %h want 0", {mst_wrt, mst_cmd}); end
    n_cmp++; if ({req_done, req_rd_data} !== 18'h0) begin n_bad++; $display("FAIL reset_req: got %h want 0", {req_done, req_rd_data}); end
    n_cmp++; if ({busy, gnt_id} !== 4'h0) begin n_bad++; $display("FAIL reset_busy_gnt: got %h want 0", {busy, gnt_id}); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    int n;
    seen_done1 = 1'b0;
    req = 2'b01;
    req_cmd[15:0] = 16'hA4FF;
    wait_wrt(n);
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL single_wrt_latency: got %0d want 1", n); end
    n_cmp++; if (mst_cmd !== 16'hA4FF) begin n_bad++; $display("FAIL single_cmd: got %h want a4ff", mst_cmd); end
    n_cmp++; if ({busy, gnt_id} !== 4'b1000) begin n_bad++; $display("FAIL single_busy_gnt: got %b want 1000", {busy, gnt_id}); end
    @(negedge clk);
    n_cmp++; if (mst_wrt !== 1'b0) begin n_bad++; $display("FAIL single_wrt_width: got %b want 0", mst_wrt); end
    mst_done = 1'b1; mst_rd_data = 16'h0012;
    @(negedge clk);
    mst_done = 1'b0;
    n_cmp++; if (req_done !== 2'b01) begin n_bad++; $display("FAIL single_done: got %b want 01", req_done); end
    n_cmp++; if (req_rd_data !== 16'h0012) begin n_bad++; $display("FAIL single_rd: got %h want 0012", req_rd_data); end
    req = 2'b00;
    @(negedge clk);
    n_cmp++; if (req_done !== 2'b00) begin n_bad++; $display("FAIL single_done_pulse: got %b want 00", req_done); end
    wait_idle(n);
    n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL single_busy_fall: got %0d want 3", n); end
    n_cmp++; if (seen_done1 !== 1'b0) begin n_bad++; $display("FAIL single_done1_leak: got %b want 0", seen_done1); end
    n_cmp++; if ({gnt_id, mst_cmd} !== {3'd0, 16'hA4FF}) begin n_bad++; $display("FAIL single_hold: got %h want 0a4ff", {gnt_id, mst_cmd}); end
  endtask

  task automatic test_rr;
    int n;
    int exp_id;
    logic [15:0] exp_cmd;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    req_cmd = {16'h0C00, 16'h0D02};
    for (int t = 0; t < 4; t++) begin
      exp_id  = t % 2;
      exp_cmd = (exp_id == 0) ? 16'h0D02 : 16'h0C00;
      wait_wrt(n);
      n_cmp++; if (n !== ((t == 0) ? 1 : 5)) begin n_bad++; $display("FAIL rr_spacing t%0d: got %0d want %0d", t, n, (t == 0) ? 1 : 5); end
      n_cmp++; if (gnt_id !== 3'(exp_id)) begin n_bad++; $display("FAIL rr_gnt t%0d: got %0d want %0d", t, gnt_id, exp_id); end
      n_cmp++; if (mst_cmd !== exp_cmd) begin n_bad++; $display("FAIL rr_cmd t%0d: got %h want %h", t, mst_cmd, exp_cmd); end
      @(negedge clk);
      mst_done = 1'b1; mst_rd_data = 16'h1000 + 16'(t);
      @(negedge clk);
      mst_done = 1'b0;
      n_cmp++; if (req_done !== ((exp_id == 0) ? 2'b01 : 2'b10)) begin n_bad++; $display("FAIL rr_done t%0d: got %b", t, req_done); end
      n_cmp++; if (req_rd_data !== 16'h1000 + 16'(t)) begin n_bad++; $display("FAIL rr_rd t%0d: got %h want %h", t, req_rd_data, 16'h1000 + 16'(t)); end
    end
    req = 2'b00;
    wait_idle(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL rr_idle: got %0d want 4", n); end
  endtask

  task automatic test_withdraw;
    int n;
    req = 2'b10;
    req_cmd[31:16] = 16'h5A5A;
    wait_wrt(n);
    n_cmp++; if ({gnt_id, mst_cmd} !== {3'd1, 16'h5A5A}) begin n_bad++; $display("FAIL wd_grant: got %h want 15a5a", {gnt_id, mst_cmd}); end
    @(negedge clk);
    req = 2'b00;
    req_cmd[31:16] = 16'hFFFF;
    @(negedge clk);
    n_cmp++; if ({busy, mst_cmd} !== {1'b1, 16'h5A5A}) begin n_bad++; $display("FAIL wd_cmd_hold: got %h want 15a5a", {busy, mst_cmd}); end
    mst_done = 1'b1; mst_rd_data = 16'h3C3C;
    @(negedge clk);
    mst_done = 1'b0;
    n_cmp++; if (req_done !== 2'b10) begin n_bad++; $display("FAIL wd_done: got %b want 10", req_done); end
    n_cmp++; if (req_rd_data !== 16'h3C3C) begin n_bad++; $display("FAIL wd_rd: got %h want 3c3c", req_rd_data); end
    wait_idle(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL wd_idle: got %0d want 4", n); end
  endtask

  task automatic test_stray;
    mst_done = 1'b1; mst_rd_data = 16'hBEEF;
    @(negedge clk);
    mst_done = 1'b0;
    n_cmp++; if ({req_done, req_rd_data} !== {2'b00, 16'h3C3C}) begin n_bad++; $display("FAIL stray_a: got %h want 03c3c", {req_done, req_rd_data}); end
    @(negedge clk);
    n_cmp++; if ({req_done, mst_wrt, busy, req_rd_data} !== {4'b0000, 16'h3C3C}) begin n_bad++; $display("FAIL stray_b: got %h want 03c3c", {req_done, mst_wrt, busy, req_rd_data}); end
  endtask

  task automatic test_gap;
    int n;
    req = 2'b01;
    req_cmd[15:0] = 16'hA5A5;
    wait_wrt(n);
    n_cmp++; if ({gnt_id, mst_cmd} !== {3'd0, 16'hA5A5}) begin n_bad++; $display("FAIL gap_grant: got %h want 0a5a5", {gnt_id, mst_cmd}); end
    @(negedge clk);
    mst_done = 1'b1; mst_rd_data = 16'h2222;
    @(negedge clk);
    mst_done = 1'b0;
    n_cmp++; if (req_done !== 2'b01) begin n_bad++; $display("FAIL gap_done: got %b want 01", req_done); end
    wait_wrt(n);
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL gap_rewrt: got %0d want 5", n); end
    @(negedge clk);
    mst_done = 1'b1; mst_rd_data = 16'h2323;
    @(negedge clk);
    mst_done = 1'b0;
    req = 2'b00;
    n_cmp++; if ({req_done, req_rd_data} !== {2'b01, 16'h2323}) begin n_bad++; $display("FAIL gap_done2: got %h want 12323", {req_done, req_rd_data}); end
    wait_idle(n);
    n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL gap_idle: got %0d want 4", n); end
  endtask

  task automatic test_reset_mid;
    int n;
    req = 2'b01;
    req_cmd[15:0] = 16'h1111;
    wait_wrt(n);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({mst_wrt, mst_cmd, req_done, req_rd_data, busy, gnt_id} !== 39'h0) begin n_bad++; $display("FAIL rm_outputs: got %h want 0", {mst_wrt, mst_cmd, req_done, req_rd_data, busy, gnt_id}); end
    @(negedge clk);
    rst = 1'b0;
    req = 2'b00;
    mst_done = 1'b1; mst_rd_data = 16'h7777;
    @(negedge clk);
    mst_done = 1'b0;
    n_cmp++; if ({req_done, req_rd_data, busy} !== 19'h0) begin n_bad++; $display("FAIL rm_late_done: got %h want 0", {req_done, req_rd_data, busy}); end
    req = 2'b11;
    req_cmd = {16'hBBBB, 16'hAAAA};
    wait_wrt(n);
    n_cmp++; if ({gnt_id, mst_cmd} !== {3'd0, 16'hAAAA}) begin n_bad++; $display("FAIL rm_first_grant: got %h want 0aaaa", {gnt_id, mst_cmd}); end
    @(negedge clk);
    mst_done = 1'b1; mst_rd_data = 16'h4444;
    @(negedge clk);
    mst_done = 1'b0;
    req = 2'b00;
    n_cmp++; if ({req_done, req_rd_data} !== {2'b01, 16'h4444}) begin n_bad++; $display("FAIL rm_done: got %h want 14444", {req_done, req_rd_data}); end
    wait_idle(n);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_withdraw();
    test_stray();
    test_gap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
